mtime_reader: RTL and testbench

Bus read initiator that fetches the 64-bit machine timer from the CLINT over its 32-bit AR/R read channel and returns a tear-free value to a local consumer, such as the CSR unit servicing `time`/`timeh` or a debug/trace unit. The timer is read high-low-high, and the sequence is retried while the two high words differ (low-word carry during the sequence). The block sits between the consumer's request/response handshake and the CLINT read port.

---
 rtl/mtime_reader_pkg.sv | 20 ++
 rtl/mtime_reader.sv | 128 ++++++++++++
 tb/tb_mtime_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtime_reader_pkg.sv
// Shared definitions for the CLINT mtime reader: FSM state encoding and
// default CLINT address map.
package mtime_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AR_H1 = 3'd1,
        R_H1  = 3'd2,
        AR_L  = 3'd3,
        R_L   = 3'd4,
        AR_H2 = 3'd5,
        R_H2  = 3'd6,
        RESP  = 3'd7
    } mtime_rd_state_t;

    localparam logic [31:0] CLINT_BASE   = 32'h0200_0000;
    localparam logic [3:0]  MTIME_LO_OFF = 4'h8;
    localparam logic [3:0]  MTIME_HI_OFF = 4'hC;

endpackage

// File: rtl/mtime_reader.sv
// Reads the 64-bit CLINT mtime over a 32-bit AR/R channel as high-low-high,
// retrying on a high-word mismatch, and hands a tear-free sample to a consumer.
module mtime_reader
    import mtime_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE,
    parameter logic [3:0]  LO_OFF    = MTIME_LO_OFF,
    parameter logic [3:0]  HI_OFF    = MTIME_HI_OFF,
    parameter int          MAX_RETRY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_time_o,
    output logic        resp_err_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i
);

    localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [31:0] ADDR_HI = BASE_ADDR + {28'd0, HI_OFF};
    localparam logic [31:0] ADDR_LO = BASE_ADDR + {28'd0, LO_OFF};
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

    mtime_rd_state_t  state;
    logic [CNT_W-1:0] retry;
    logic [31:0]      hi1;
    logic [31:0]      lo;

    // All outputs are registered; araddr_o is held through each R phase
    // because the CLINT decodes rdata from the live address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            retry        <= '0;
            hi1          <= '0;
            lo           <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_time_o  <= '0;
            resp_err_o   <= 1'b0;
            arvalid_o    <= 1'b0;
            araddr_o     <= '0;
            rready_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        retry       <= '0;
                        req_ready_o <= 1'b0;
                        arvalid_o   <= 1'b1;
                        araddr_o    <= ADDR_HI;
                        state       <= AR_H1;
                    end
                end
                AR_H1, AR_L, AR_H2: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        case (state)
                            AR_H1:   state <= R_H1;
                            AR_L:    state <= R_L;
                            default: state <= R_H2;
                        endcase
                    end
                end
                R_H1: begin
                    if (rvalid_i) begin
                        hi1       <= rdata_i;
                        rready_o  <= 1'b0;
                        arvalid_o <= 1'b1;
                        araddr_o  <= ADDR_LO;
                        state     <= AR_L;
                    end
                end
                R_L: begin
                    if (rvalid_i) begin
                        lo        <= rdata_i;
                        rready_o  <= 1'b0;
                        arvalid_o <= 1'b1;
                        araddr_o  <= ADDR_HI;
                        state     <= AR_H2;
                    end
                end
                R_H2: begin
                    if (rvalid_i) begin
                        rready_o <= 1'b0;
                        // The second high word is compared as it arrives.
                        if (rdata_i == hi1) begin
                            resp_time_o  <= {hi1, lo};
                            resp_err_o   <= 1'b0;
                            resp_valid_o <= 1'b1;
                            state        <= RESP;
                        end else if (retry < RETRY_LIMIT) begin
                            retry     <= retry + 1'b1;
                            arvalid_o <= 1'b1;
                            araddr_o  <= ADDR_HI;
                            state     <= AR_H1;
                        end else begin
                            resp_time_o  <= {rdata_i, lo};
                            resp_err_o   <= 1'b1;
                            resp_valid_o <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtime_reader.sv
// Directed bench for mtime_reader with a behavioural CLINT responder
// supporting fixed, scripted and free-running mtime plus AR/R stalls.
module tb_mtime_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_time_o;
    logic        resp_err_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;

    mtime_reader dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_time_o  (resp_time_o),
        .resp_err_o   (resp_err_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .araddr_o     (araddr_o),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .rdata_i      (rdata_i)
    );

    always #5 clock = ~clock;

    // Responder model: mode 0 fixed mtime, 1 scripted words, 2 free-running counter.
    int          mode = 0;
    logic [63:0] mtime_fixed = '0;
    logic [31:0] script [0:15];
    int          ar_delay = 0;
    int          r_delay = 0;

    int          ar_cnt, r_cnt, rd_idx, ar_hs, viol, both_high;
    logic [31:0] ar_log [0:15];
    logic [63:0] clint_cnt;
    logic [31:0] last_addr;
    logic        ar_pend, r_pend;
    logic [63:0] cur_mtime;

    assign arready_i = (ar_cnt >= ar_delay);
    assign rvalid_i  = rready_o && (r_cnt >= r_delay);
    assign cur_mtime = (mode == 2) ? clint_cnt : mtime_fixed;

    always_comb begin
        rdata_i = 32'hDEAD_BEEF;
        if (mode == 1)
            rdata_i = script[rd_idx % 16];
        else if (araddr_o == 32'h0200_000C)
            rdata_i = cur_mtime[63:32];
        else if (araddr_o == 32'h0200_0008)
            rdata_i = cur_mtime[31:0];
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ar_cnt    <= 0;
            r_cnt     <= 0;
            rd_idx    <= 0;
            ar_hs     <= 0;
            viol      <= 0;
            clint_cnt <= '0;
            last_addr <= '0;
            ar_pend   <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            clint_cnt <= clint_cnt + 64'd1;
            if (arvalid_o && !arready_i) ar_cnt <= ar_cnt + 1;
            else ar_cnt <= 0;
            if (rready_o && !rvalid_i) r_cnt <= r_cnt + 1;
            else r_cnt <= 0;
            if (arvalid_o && arready_i) begin
                ar_log[ar_hs % 16] <= araddr_o;
                ar_hs <= ar_hs + 1;
            end
            if (rvalid_i && rready_o) rd_idx <= rd_idx + 1;
            if ((ar_pend || r_pend) && araddr_o != last_addr) viol <= viol + 1;
            else if (ar_pend && !arvalid_o) viol <= viol + 1;
            else if (r_pend && !rready_o) viol <= viol + 1;
            ar_pend   <= arvalid_o && !arready_i;
            r_pend    <= rready_o && !rvalid_i;
            last_addr <= araddr_o;
        end
    end

    initial both_high = 0;
    always @(negedge clock) if (req_ready_o && resp_valid_o) both_high++;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Cycle index 1 is the cycle right after the request handshake edge.
    task automatic run_req(output logic [63:0] t, output logic e, output int cyc);
        req_valid_i = 1'b1;
        @(posedge clock);
        #1;
        req_valid_i = 1'b0;
        cyc = 1;
        while (!resp_valid_o && cyc < 400) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        t = resp_time_o;
        e = resp_err_o;
    endtask

    task automatic take();
        resp_ready_i = 1'b1;
        @(posedge clock);
        #1;
        resp_ready_i = 1'b0;
    endtask

    logic [63:0] t, t1, t2, hold_t;
    logic        e, stable;
    int          cyc;

    initial begin
        for (int i = 0; i < 16; i++) script[i] = '0;

        // Reset state
        do_reset();
        check("rst_flags", {59'd0, req_ready_o, resp_valid_o, resp_err_o, arvalid_o, rready_o},
              64'b10000);
        check("rst_addr", {32'd0, araddr_o}, 64'd0);
        check("rst_time", resp_time_o, 64'd0);

        // Steady read
        mode = 0;
        mtime_fixed = 64'h0000_0005_0000_0100;
        run_req(t, e, cyc);
        check("steady_valid", {63'd0, resp_valid_o}, 64'd1);
        check("steady_time", t, 64'h0000_0005_0000_0100);
        check("steady_err", {63'd0, e}, 64'd0);
        check("steady_cyc", 64'(cyc), 64'd7);
        check("steady_nready", {63'd0, req_ready_o}, 64'd0);
        check("steady_ar_hs", 64'(ar_hs), 64'd3);
        check("steady_addr0", {32'd0, ar_log[0]}, 64'h0200_000C);
        check("steady_addr1", {32'd0, ar_log[1]}, 64'h0200_0008);
        check("steady_addr2", {32'd0, ar_log[2]}, 64'h0200_000C);
        take();
        check("steady_idle", {62'd0, req_ready_o, resp_valid_o}, 64'b10);

        // Carry during sequence: one retry
        do_reset();
        mode = 1;
        script[0] = 32'd1; script[1] = 32'hFFFF_FFFF; script[2] = 32'd2;
        script[3] = 32'd2; script[4] = 32'd3;         script[5] = 32'd2;
        run_req(t, e, cyc);
        check("carry_time", t, 64'h0000_0002_0000_0003);
        check("carry_err", {63'd0, e}, 64'd0);
        check("carry_cyc", 64'(cyc), 64'd13);
        check("carry_ar_hs", 64'(ar_hs), 64'd6);
        take();

        // Exhausted retries: high words never agree
        do_reset();
        for (int k = 0; k < 4; k++) begin
            script[3*k]   = 32'd10 + 32'(k);
            script[3*k+1] = 32'h100 + 32'(k);
            script[3*k+2] = 32'd20 + 32'(k);
        end
        run_req(t, e, cyc);
        check("exh_time", t, {32'd23, 32'h103});
        check("exh_err", {63'd0, e}, 64'd1);
        check("exh_ar_hs", 64'(ar_hs), 64'd12);
        check("exh_cyc", 64'(cyc), 64'd25);
        take();

        // Backpressure on AR, R and response
        do_reset();
        mode = 0;
        mtime_fixed = 64'h1234_5678_9ABC_DEF0;
        ar_delay = 3;
        r_delay = 4;
        req_valid_i = 1'b1;
        @(posedge clock);
        #1;
        req_valid_i = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(arvalid_o && araddr_o == 32'h0200_000C)) stable = 1'b0;
            @(posedge clock);
            #1;
        end
        check("bp_ar_stable", {63'd0, stable}, 64'd1);
        cyc = 4;
        while (!resp_valid_o && cyc < 400) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("bp_cyc", 64'(cyc), 64'd28);
        check("bp_time", resp_time_o, 64'h1234_5678_9ABC_DEF0);
        check("bp_hold_viol", 64'(viol), 64'd0);
        hold_t = resp_time_o;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (!(resp_valid_o && resp_time_o == hold_t && !resp_err_o)) stable = 1'b0;
        end
        check("bp_resp_stable", {63'd0, stable}, 64'd1);
        take();
        ar_delay = 0;
        r_delay = 0;

        // Reset while in R_L
        mtime_fixed = 64'h7777_0000_1111_2222;
        req_valid_i = 1'b1;
        @(posedge clock);
        #1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_in_rl", {31'd0, rready_o, araddr_o}, {31'd0, 1'b1, 32'h0200_0008});
        reset = 1'b0;
        #1;
        check("mid_rst_flags", {59'd0, req_ready_o, resp_valid_o, resp_err_o, arvalid_o, rready_o},
              64'b10000);
        check("mid_rst_addr", {32'd0, araddr_o}, 64'd0);
        check("mid_rst_time", resp_time_o, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mtime_fixed = 64'hABCD_0000_1234_5678;
        run_req(t, e, cyc);
        check("post_rst_time", t, 64'hABCD_0000_1234_5678);
        check("post_rst_err", {63'd0, e}, 64'd0);
        check("post_rst_cyc", 64'(cyc), 64'd7);
        take();

        // Free-running CLINT: back-to-back requests
        do_reset();
        mode = 2;
        run_req(t1, e, cyc);
        take();
        run_req(t2, e, cyc);
        take();
        check("clint_increase", {63'd0, (t2 > t1)}, 64'd1);
        check("clint_delta", {63'd0, ((t2 - t1) >= 64'd7)}, 64'd1);
        check("clint_err", {63'd0, e}, 64'd0);

        check("never_both_high", 64'(both_high), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
